tick_counter: RTL and testbench
===============================

# tick_counter

Synchronous up-counter with a parallel load, a one-cycle wrap pulse and a compare output. It produces the periodic event bits of the Turing Complete tick path. Its `wrap` and `match` outputs feed the existing `OR_GATE`, which merges them into a single tick-event line for the downstream logic.

## Interface
Parameters:
- `WIDTH`, default 8: counter, load and compare width in bits (legal range 2–32).

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `en`  input  1  count enable; increments `out` by 1 per cycle while high.
- `load`  input  1  synchronous load; `out <= load_val` on the next edge.
- `load_val`  input  WIDTH  value captured when `load` is high.
- `cmp_val`  input  WIDTH  compare value for `match`.
- `out`  output  WIDTH  current count, registered.
- `wrap`  output  1  registered wrap indicator (see Operation and Configuration).
- `match`  output  1  combinational: high when `out == cmp_val`.

## Operation
- Priority per edge: reset, then `load`, then `en`, then hold.
- `load` high:
  - `out <= load_val`.
  - `wrap <= 0`, regardless of `en`.
- `load` low, `en` high, `out != {WIDTH{1'b1}}`:
  - `out <= out + 1`.
  - `wrap <= 0`.
- `load` low, `en` high, `out == {WIDTH{1'b1}}`:
  - Default build: `out <= 0` (modulo 2^WIDTH) and `wrap <= 1` for exactly one cycle.
  - Saturating build: see Configuration.
- `load` low, `en` low:
  - `out` holds.
  - Default build: `wrap <= 0`.
- Arithmetic is unsigned WIDTH-bit. No carry is kept beyond `wrap`.
- `match` is a pure compare of registered `out` against live `cmp_val`, so it can change mid-cycle when `cmp_val` changes.
- Internal state: two modes, RUN and SAT. SAT exists only in the saturating build.
  - RUN → SAT on an enabled increment at all-ones.
  - SAT → RUN on `load` or reset.

## Timing
- Reset (`rst_n` low, asynchronous): `out = 0`, `wrap = 0`, mode = RUN, immediately and without waiting for `clk`.
- `match` follows `out` and `cmp_val` combinationally. With `cmp_val = 0`, `match` is 1 during reset.
- Reset release: the first state update happens on the first rising edge where `rst_n` is high. No extra latency cycles.
- Load latency: 1 cycle. `out` shows `load_val` after the edge that sampled `load = 1`.
- Count latency: 1 cycle per increment. No bubbles across the wrap.
- `wrap` timing: asserted in the same cycle that `out` shows 0 after wrapping. Deasserted on the next edge unless another wrap occurs.
  - A wrap on two consecutive edges can only happen with WIDTH ≥ 2 if `load` reloads all-ones; in that case `load` wins and `wrap` is 0.
- `load` and `en` high together: the load wins and no increment occurs. If the current `out` is all-ones, no wrap is flagged.
- `load_val = all-ones` with `en` high on the next cycle: wrap on that following edge.
- Reset mid-count or mid-wrap-pulse: `out` and `wrap` clear immediately. No residual pulse after release.

## Configuration
- Macro: `TICK_COUNTER_SATURATE_EN`.
- Undefined (default): modulo counter as described. `wrap` is a one-cycle pulse per rollover.
- Defined:
  - An enabled increment at all-ones leaves `out` at all-ones and enters SAT.
  - `wrap` becomes a sticky level: it goes to 1 on that edge and stays 1 while in SAT, regardless of `en`.
  - `load` or reset clears `wrap` and returns the counter to RUN.
  - `out` never returns to 0 except by load or reset.
- Port list and reset values are identical in both builds.

## Test plan
All scenarios use WIDTH = 8.
1. Reset: hold `rst_n = 0` with `en = 1` toggling `clk`, then release and count 5 edges → `out = 0`, `wrap = 0` during reset; `out = 5` after 5 enabled edges.
2. Load priority: `load_val = 8'hA5` with `load = 1` and `en = 1` for one edge → `out = 8'hA5`, no increment. The next enabled edge gives `out = 8'hA6`.
3. Wrap (default build): load `8'hFE`, then `en = 1` for 3 edges → `out` goes FF, 00, 01; `wrap = 1` only in the cycle where `out = 00`.
4. Match: `cmp_val = 8'h03`, count up from 0 → `match = 1` only while `out = 3`. Changing `cmp_val` to `8'h04` while `out = 4` raises `match` in the same cycle.
5. Async reset during the wrap pulse: drop `rst_n` while `wrap = 1` → `out = 0` and `wrap = 0` before the next `clk` edge. No pulse after release.
6. Saturating build (`TICK_COUNTER_SATURATE_EN`): load FE, then 4 enabled edges → `out` goes FF, FF, FF, FF; `wrap` is 1 from the second edge on. A later `load_val = 8'h10` load gives `out = 10`, `wrap = 0`.

Source files
------------

// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_counter
//  Description : Up-counter with parallel load, wrap indicator and a
//                combinational compare output. Produces the periodic event
//                bits (wrap, match) of the tick path.
//                Optional macro TICK_COUNTER_SATURATE_EN selects a saturating
//                counter with a sticky wrap level instead of a modulo counter
//                with a one-cycle wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             match
);

    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;

`ifdef TICK_COUNTER_SATURATE_EN
    // SAT is entered on an enabled increment at all-ones and left only by
    // a load or reset; while in SAT the count is pinned at all-ones.
    typedef enum logic [0:0] {
        MODE_RUN = 1'b0,
        MODE_SAT = 1'b1
    } mode_t;

    mode_t mode_q;
    mode_t mode_d;

    // Next-state: load beats everything, SAT holds a sticky wrap level.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        mode_d  = mode_q;
        if (load) begin
            count_d = load_val;
            mode_d  = MODE_RUN;
        end else if (mode_q == MODE_SAT) begin
            wrap_d  = 1'b1;
        end else if (en) begin
            if (count_q == C_ALL_ONES) begin
                wrap_d = 1'b1;
                mode_d = MODE_SAT;
            end else begin
                count_d = count_q + C_ONE;
            end
        end
    end

    // Mode register, cleared to RUN asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    // Next-state: load beats enable; rollover to zero raises a single-cycle pulse.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + C_ONE;
            wrap_d  = (count_q == C_ALL_ONES);
        end
    end
`endif

    // Count and wrap registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out   = count_q;
    assign wrap  = wrap_q;
    // Live compare: follows cmp_val changes within the cycle.
    assign match = (count_q == cmp_val);

endmodule
`default_nettype wire

// File: tb/tb_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_counter
//  Description : Scoreboard bench for tick_counter (WIDTH = 8). Stimulus
//                pushes hand-computed expectations; a monitor pops and
//                compares when a sample is announced. Build-dependent
//                expectations follow TICK_COUNTER_SATURATE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] cmp_val;
    logic [7:0] out;
    logic       wrap;
    logic       match;

    tick_counter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .cmp_val  (cmp_val),
        .out      (out),
        .wrap     (wrap),
        .match    (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic       w;
        logic       m;
        int         id;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_push = 0;

    // Queue an expectation against the current cmp_val and announce a sample.
    task automatic check(input logic [7:0] eo, input logic ew);
        exp_t e;
        e.o  = eo;
        e.w  = ew;
        e.m  = (eo == cmp_val);
        e.id = n_push;
        n_push++;
        q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // Apply inputs for one rising edge, then check the registered result.
    task automatic step(input logic e_i, input logic l_i, input logic [7:0] lv,
                        input logic [7:0] eo, input logic ew);
        en       = e_i;
        load     = l_i;
        load_val = lv;
        @(posedge clk);
        #2;
        check(eo, ew);
    endtask

    // Monitor: pops and compares every queued expectation on each sample.
    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (out !== e.o || wrap !== e.w || match !== e.m) begin
                    n_err++;
                    $display("FAIL vec%0d: got out=%h wrap=%b match=%b, expected out=%h wrap=%b match=%b",
                             e.id, out, wrap, match, e.o, e.w, e.m);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n    = 1'b0;
        en       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        cmp_val  = 8'h00;

        // 1. Reset held with en high: counter stays 0, match high with cmp 0.
        repeat (3) @(posedge clk);
        #2;
        check(8'h00, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'h00, 8'(i), 1'b0);

        // 2. Load beats enable, then increment resumes.
        step(1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'hA6, 1'b0);

        // 3 / 6. Rollover behaviour from FE.
        cmp_val = 8'h77;
        step(1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0);
`ifdef TICK_COUNTER_SATURATE_EN
        step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'hFF, 1'b1);   // sticky regardless of en
        step(1'b1, 1'b1, 8'h10, 8'h10, 1'b0);
`else
        step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h01, 1'b0);   // hold
`endif

        // Load at all-ones with en: no wrap; all-ones load then en wraps next edge.
        step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
`ifdef TICK_COUNTER_SATURATE_EN
        step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
`else
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
`endif

        // 4. Match against live cmp_val.
        cmp_val = 8'h03;
        step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h02, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h04, 1'b0);
        cmp_val = 8'h04;
        #1;
        check(8'h04, 1'b0);                      // same-cycle match rise
        step(1'b0, 1'b0, 8'h00, 8'h04, 1'b0);

        // 5. Asynchronous reset while wrap is high.
        cmp_val = 8'h55;
        step(1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
`ifdef TICK_COUNTER_SATURATE_EN
        step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
`else
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
`endif
        rst_n = 1'b0;
        #1;
        check(8'h00, 1'b0);                      // cleared before any edge
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);   // edge while still in reset
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h00, 8'h01, 1'b0);   // no residual pulse
        step(1'b1, 1'b0, 8'h00, 8'h02, 1'b0);

        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
